// File: rtl/pipeline_shift_reg.sv
// pipeline_shift_reg
// Four-stage register spine (data_i -> data_1 -> data_2 -> data_3 -> data_4)
// modelling the IF/ID/EX/MEM/WB pipeline registers for pipeline-control
// experiments. A synchronous flush inserts bubbles (zero) into every stage,
// and a stall freezes the whole chain. Priority on each rising edge is
// rst > flush > stall > shift. Every output comes straight from a register.
//
// Optional feature: define PIPE_VALID_EN to add the valid_o port, a per-stage
// valid bit that distinguishes real data from bubbles. Without the macro the
// port and its logic are absent and the data path behaves identically.

module pipeline_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] data_2,
    output logic [WIDTH-1:0] data_3,
    output logic [WIDTH-1:0] data_4
`ifdef PIPE_VALID_EN
    ,
    output logic [3:0]       valid_o
`endif
);

    // What the chain does on the next edge when reset is not asserted.
    typedef enum logic [1:0] {
        OP_SHIFT = 2'd0,
        OP_HOLD  = 2'd1,
        OP_CLEAR = 2'd2
    } stage_op_t;

    stage_op_t        w_stageOp;

    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic [WIDTH-1:0] r_stage3;
    logic [WIDTH-1:0] r_stage4;

    // Decode flush/stall into a single operation; flush outranks stall.
    always_comb begin
        w_stageOp = OP_SHIFT;
        if (flush) begin
            w_stageOp = OP_CLEAR;
        end else if (stall) begin
            w_stageOp = OP_HOLD;
        end
    end

    // Stage registers: synchronous reset first, then clear, hold or shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
            r_stage3 <= '0;
            r_stage4 <= '0;
        end else begin
            unique case (w_stageOp)
                OP_CLEAR: begin
                    r_stage1 <= '0;
                    r_stage2 <= '0;
                    r_stage3 <= '0;
                    r_stage4 <= '0;
                end
                OP_HOLD: begin
                    r_stage1 <= r_stage1;
                    r_stage2 <= r_stage2;
                    r_stage3 <= r_stage3;
                    r_stage4 <= r_stage4;
                end
                OP_SHIFT: begin
                    r_stage1 <= data_i;
                    r_stage2 <= r_stage1;
                    r_stage3 <= r_stage2;
                    r_stage4 <= r_stage3;
                end
                default: begin
                    r_stage1 <= r_stage1;
                    r_stage2 <= r_stage2;
                    r_stage3 <= r_stage3;
                    r_stage4 <= r_stage4;
                end
            endcase
        end
    end

    assign data_1 = r_stage1;
    assign data_2 = r_stage2;
    assign data_3 = r_stage3;
    assign data_4 = r_stage4;

`ifdef PIPE_VALID_EN
    logic [3:0] r_valid;

    // Valid bits travel with the data: a 1 enters stage 1 on every shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 4'b0000;
        end else begin
            unique case (w_stageOp)
                OP_CLEAR: r_valid <= 4'b0000;
                OP_HOLD:  r_valid <= r_valid;
                OP_SHIFT: r_valid <= {r_valid[2:0], 1'b1};
                default:  r_valid <= r_valid;
            endcase
        end
    end

    assign valid_o = r_valid;
`endif

endmodule

// File: tb/tb_pipeline_shift_reg.sv
// tb_pipeline_shift_reg
// Self-checking bench for pipeline_shift_reg (WIDTH = 8). A vector table
// walks through reset, fill, flush, stall, resume and priority cases; short
// hand-written sequences cover mid-stream reset and multi-cycle stalls; a
// random phase runs against a small reference model. Expected values are
// queued when stimulus is driven and popped when the outputs are sampled.
// Define PIPE_VALID_EN to also check valid_o.

module tb_pipeline_shift_reg;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic [7:0]  din;
        logic [31:0] expData;
        logic [3:0]  expValid;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
        string       name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       stall;
    logic [7:0] dataIn;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [7:0] data3;
    logic [7:0] data4;
`ifdef PIPE_VALID_EN
    logic [3:0] validOut;
`endif

    int   testsRun;
    int   testsFailed;
    exp_t expQ[$];
    vec_t vecs[$];

    // Bench-side reference state for the random phase.
    logic [7:0] mData [4];
    logic [3:0] mValid;

    pipeline_shift_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .stall  (stall),
        .data_i (dataIn),
        .data_1 (data1),
        .data_2 (data2),
        .data_3 (data3),
        .data_4 (data4)
`ifdef PIPE_VALID_EN
        ,
        .valid_o(validOut)
`endif
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic r, input logic f, input logic s,
                                   input logic [7:0] d, input logic [31:0] ed,
                                   input logic [3:0] ev, input string nm);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.din = d;
        v.expData = ed; v.expValid = ev; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Pop the oldest expectation and compare it with the sampled outputs.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: output sampled with no expectation queued");
            return;
        end
        e = expQ.pop_front();
        testsRun++;
        if ({data1, data2, data3, data4} !== e.data) begin
            testsFailed++;
            $display("[TB] FAIL %s data: got %h/%h/%h/%h expected %h/%h/%h/%h",
                     e.name, data1, data2, data3, data4,
                     e.data[31:24], e.data[23:16], e.data[15:8], e.data[7:0]);
        end
`ifdef PIPE_VALID_EN
        testsRun++;
        if (validOut !== e.valid) begin
            testsFailed++;
            $display("[TB] FAIL %s valid: got %b expected %b", e.name, validOut, e.valid);
        end
`endif
    endtask

    // Drive one cycle of inputs (called just after a falling edge), queue the
    // expectation, let the rising edge happen and check 1 time unit later.
    task automatic applyStimulus(input logic r, input logic f, input logic s,
                                 input logic [7:0] d, input logic [31:0] ed,
                                 input logic [3:0] ev, input string nm);
        exp_t e;
        rst    = r;
        flush  = f;
        stall  = s;
        dataIn = d;
        e.data = ed; e.valid = ev; e.name = nm;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    // Advance the reference model by one edge using the documented priority.
    task automatic stepModel(input logic r, input logic f, input logic s,
                             input logic [7:0] d);
        if (r || f) begin
            for (int k = 0; k < 4; k++) mData[k] = 8'h00;
            mValid = 4'b0000;
        end else if (!s) begin
            mData[3] = mData[2];
            mData[2] = mData[1];
            mData[1] = mData[0];
            mData[0] = d;
            mValid   = {mValid[2:0], 1'b1};
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        stall  = 1'b0;
        dataIn = 8'h00;

        // rst, flush, stall, data_i, expected data_1..4, expected valid
        addVec(1, 0, 0, 8'h00, 32'h00000000, 4'b0000, "reset_e5");
        addVec(1, 0, 0, 8'h00, 32'h00000000, 4'b0000, "reset_e15");
        addVec(0, 0, 0, 8'h44, 32'h44000000, 4'b0001, "fill_44");
        addVec(0, 0, 0, 8'h33, 32'h33440000, 4'b0011, "fill_33");
        addVec(0, 0, 0, 8'h22, 32'h22334400, 4'b0111, "fill_22");
        addVec(0, 0, 0, 8'h11, 32'h11223344, 4'b1111, "fill_11");
        addVec(0, 1, 0, 8'hFF, 32'h00000000, 4'b0000, "flush_1");
        addVec(0, 1, 0, 8'hFF, 32'h00000000, 4'b0000, "flush_2");
        addVec(0, 0, 0, 8'hAA, 32'hAA000000, 4'b0001, "refill_1");
        addVec(0, 0, 0, 8'hAA, 32'hAAAA0000, 4'b0011, "refill_2");
        addVec(0, 0, 0, 8'hAA, 32'hAAAAAA00, 4'b0111, "refill_3");
        addVec(0, 0, 1, 8'hBB, 32'hAAAAAA00, 4'b0111, "stall_1");
        addVec(0, 0, 1, 8'hBB, 32'hAAAAAA00, 4'b0111, "stall_2");
        addVec(0, 0, 0, 8'hCC, 32'hCCAAAAAA, 4'b1111, "resume_CC");
        addVec(0, 0, 0, 8'hDD, 32'hDDCCAAAA, 4'b1111, "resume_DD1");
        addVec(0, 0, 0, 8'hDD, 32'hDDDDCCAA, 4'b1111, "resume_DD2");
        addVec(0, 0, 0, 8'hDD, 32'hDDDDDDCC, 4'b1111, "resume_DD3");
        addVec(0, 0, 0, 8'hDD, 32'hDDDDDDDD, 4'b1111, "resume_DD4");
        addVec(0, 1, 1, 8'h55, 32'h00000000, 4'b0000, "prio_flush_over_stall");
        addVec(1, 0, 0, 8'h77, 32'h00000000, 4'b0000, "prio_reset");
        addVec(0, 0, 0, 8'h01, 32'h01000000, 4'b0001, "shift_01");
        addVec(0, 0, 0, 8'h02, 32'h02010000, 4'b0011, "shift_02");
        addVec(0, 0, 0, 8'h03, 32'h03020100, 4'b0111, "shift_03");
        addVec(0, 0, 0, 8'h04, 32'h04030201, 4'b1111, "shift_04");
        addVec(1, 0, 1, 8'h99, 32'h00000000, 4'b0000, "prio_reset_over_stall");
        addVec(1, 1, 0, 8'h99, 32'h00000000, 4'b0000, "prio_reset_over_flush");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].din,
                          vecs[i].expData, vecs[i].expValid, vecs[i].name);
        end

        // Mid-stream reset: clears on its own edge, shifting resumes right after.
        applyStimulus(0, 0, 0, 8'h11, 32'h11000000, 4'b0001, "mid_fill_1");
        applyStimulus(0, 0, 0, 8'h22, 32'h22110000, 4'b0011, "mid_fill_2");
        applyStimulus(0, 0, 0, 8'h33, 32'h33221100, 4'b0111, "mid_fill_3");
        applyStimulus(1, 0, 0, 8'h44, 32'h00000000, 4'b0000, "mid_reset");
        applyStimulus(0, 0, 0, 8'h55, 32'h55000000, 4'b0001, "mid_resume");

        // Stall held three cycles, then latency of 55 through to stage 4.
        applyStimulus(0, 0, 1, 8'h66, 32'h55000000, 4'b0001, "long_stall_1");
        applyStimulus(0, 0, 1, 8'h66, 32'h55000000, 4'b0001, "long_stall_2");
        applyStimulus(0, 0, 1, 8'h66, 32'h55000000, 4'b0001, "long_stall_3");
        applyStimulus(0, 0, 0, 8'h66, 32'h66550000, 4'b0011, "lat_2");
        applyStimulus(0, 0, 0, 8'h77, 32'h77665500, 4'b0111, "lat_3");
        applyStimulus(0, 0, 0, 8'h88, 32'h88776655, 4'b1111, "lat_4");

        // Random phase against the reference model, seeded from the known state.
        mData[0] = 8'h88; mData[1] = 8'h77; mData[2] = 8'h66; mData[3] = 8'h55;
        mValid   = 4'b1111;
        for (int n = 0; n < 60; n++) begin
            logic       r;
            logic       f;
            logic       s;
            logic [7:0] d;
            r = ($urandom_range(0, 15) == 0);
            f = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = 8'($urandom_range(1, 255));
            stepModel(r, f, s, d);
            applyStimulus(r, f, s, d, {mData[0], mData[1], mData[2], mData[3]},
                          mValid, "random");
        end

        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
